stack_engine: RTL and testbench

- Parametrised hardware stack; successor to the fixed 16-bit stack pointer plus data-memory push/pop path.
- Holds up to DEPTH words in internal registers and exposes the top of stack.
- Supports push, pop, simultaneous push+pop (replace top) and synchronous clear.
- Provides full/empty status and sticky overflow/underflow error flags.
- Sits beside the control unit: the control unit drives push/pop, and the accumulator or register file supplies data_in.

---
 rtl/stack_engine.sv | 126 ++++++++++++
 tb/tb_stack_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_engine.sv
// Register-based LIFO stack with top-of-stack view, replace-top, synchronous clear
// and sticky overflow/underflow flags.
module stack_engine #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] top_out,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] storage [DEPTH];

  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] top_q, top_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_en;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic                  full_c, empty_c;

  assign full_c  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty_c = (count_q == '0);

  // Entry that becomes the top after a pop; only meaningful when count >= 2.
  assign rd_idx = IDX_WIDTH'(count_q - CNT_WIDTH'(2));

  // Next-state decode of the operation table on the registered count.
  always_comb begin
    count_d     = count_q;
    top_d       = top_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    ovf_d       = ovf_q & ~err_clr;
    unf_d       = unf_q & ~err_clr;
    wr_en       = 1'b0;
    wr_idx      = IDX_WIDTH'(count_q);

    if (clear) begin
      count_d = '0;
      top_d   = '0;
    end else if (push && pop) begin
      if (empty_c) begin
        wr_en   = 1'b1;
        wr_idx  = '0;
        count_d = CNT_WIDTH'(1);
        top_d   = data_in;
        unf_d   = 1'b1;
      end else begin
        pop_data_d  = top_q;
        pop_valid_d = 1'b1;
        wr_en       = 1'b1;
        wr_idx      = IDX_WIDTH'(count_q - CNT_WIDTH'(1));
        top_d       = data_in;
      end
    end else if (push) begin
      if (full_c) begin
        ovf_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        count_d = count_q + CNT_WIDTH'(1);
        top_d   = data_in;
      end
    end else if (pop) begin
      if (empty_c) begin
        unf_d = 1'b1;
      end else begin
        pop_data_d  = top_q;
        pop_valid_d = 1'b1;
        count_d     = count_q - CNT_WIDTH'(1);
        top_d       = (count_q >= CNT_WIDTH'(2)) ? storage[rd_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      top_q       <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      top_q       <= top_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Storage contents are don't-care after reset, so no reset is applied here.
  always_ff @(posedge clk) begin
    if (wr_en) storage[wr_idx] <= data_in;
  end

  assign top_out   = top_q;
  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign count     = count_q;
  assign full      = full_c;
  assign empty     = empty_c;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_stack_engine.sv
// Scoreboard bench for stack_engine: queue-based reference stack, directed scenarios
// followed by randomized traffic, monitor compares on every falling edge.
module tb_stack_engine;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0, pop = 1'b0, clear = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] top_out, pop_data;
  logic          pop_valid, full, empty, overflow, underflow;
  logic [CW-1:0] count;

  stack_engine #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .clear(clear),
    .err_clr(err_clr), .data_in(data_in), .top_out(top_out), .pop_data(pop_data),
    .pop_valid(pop_valid), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model state (committed after each clock edge).
  logic [DW-1:0] mstack [$];
  logic [DW-1:0] exp_q  [$];
  logic          m_ovf = 1'b0, m_unf = 1'b0, m_pv = 1'b0;
  logic [DW-1:0] m_last = '0;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] m_top();
    return (mstack.size() == 0) ? '0 : mstack[mstack.size()-1];
  endfunction

  // Drive one command, let the DUT take it, then commit the model's view.
  task automatic step(input bit pu, input bit po, input bit cl, input bit ec,
                      input logic [DW-1:0] d);
    logic [DW-1:0] ns [$];
    logic          novf, nunf, npv;
    logic [DW-1:0] popped;
    bit            has_pop;
    ns      = mstack;
    novf    = m_ovf && !ec;
    nunf    = m_unf && !ec;
    npv     = 1'b0;
    has_pop = 1'b0;
    popped  = '0;
    if (cl) begin
      ns.delete();
    end else if (pu && po) begin
      if (ns.size() == 0) begin
        ns.push_back(d);
        nunf = 1'b1;
      end else begin
        popped = ns[ns.size()-1];
        has_pop = 1'b1;
        ns[ns.size()-1] = d;
      end
    end else if (pu) begin
      if (ns.size() == DEPTH) novf = 1'b1;
      else ns.push_back(d);
    end else if (po) begin
      if (ns.size() == 0) nunf = 1'b1;
      else begin
        popped = ns.pop_back();
        has_pop = 1'b1;
      end
    end
    push = pu; pop = po; clear = cl; err_clr = ec; data_in = d;
    @(posedge clk);
    mstack = ns;
    m_ovf  = novf;
    m_unf  = nunf;
    npv    = has_pop;
    m_pv   = npv;
    if (has_pop) begin
      exp_q.push_back(popped);
      m_last = popped;
    end
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0; err_clr = 1'b0; data_in = '0;
  endtask

  task automatic model_reset();
    mstack.delete();
    exp_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_pv = 1'b0; m_last = '0;
  endtask

  // Monitor: full-state comparison plus pop_data scoreboard on every pop_valid.
  always @(negedge clk) begin
    if (reset) begin
      chk("count",     32'(count),     32'(mstack.size()));
      chk("top_out",   32'(top_out),   32'(m_top()));
      chk("full",      32'(full),      32'(mstack.size() == DEPTH));
      chk("empty",     32'(empty),     32'(mstack.size() == 0));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      chk("pop_valid", 32'(pop_valid), 32'(m_pv));
      chk("pop_data_hold", 32'(pop_data), 32'(m_last));
      if (pop_valid) begin
        if (exp_q.size() == 0) chk("sb_unexpected_pop", 32'(1), 32'(0));
        else chk("sb_pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"},     32'(count),     32'(0));
    chk({tag, "_top"},       32'(top_out),   32'(0));
    chk({tag, "_pop_data"},  32'(pop_data),  32'(0));
    chk({tag, "_pop_valid"}, 32'(pop_valid), 32'(0));
    chk({tag, "_ovf"},       32'(overflow),  32'(0));
    chk({tag, "_unf"},       32'(underflow), 32'(0));
    chk({tag, "_empty"},     32'(empty),     32'(1));
    chk({tag, "_full"},      32'(full),      32'(0));
  endtask

  initial begin
    int op;
    #1;
    check_reset_state("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Three pushes then three pops.
    step(1, 0, 0, 0, 16'h1111);
    step(1, 0, 0, 0, 16'h2222);
    step(1, 0, 0, 0, 16'h3333);
    chk("p3_count", 32'(count), 32'(3));
    chk("p3_top", 32'(top_out), 32'h3333);
    step(0, 1, 0, 0, '0);
    chk("pop1_data", 32'(pop_data), 32'h3333);
    step(0, 1, 0, 0, '0);
    chk("pop2_data", 32'(pop_data), 32'h2222);
    step(0, 1, 0, 0, '0);
    chk("pop3_data", 32'(pop_data), 32'h1111);
    chk("pop3_empty", 32'(empty), 32'(1));
    step(0, 0, 0, 0, '0);

    // Fill, overflow, error clear.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, DW'(i));
    chk("fill_full", 32'(full), 32'(1));
    step(1, 0, 0, 0, 16'hBEEF);
    chk("ovf_set", 32'(overflow), 32'(1));
    chk("ovf_top", 32'(top_out), 32'(DEPTH - 1));
    step(0, 0, 0, 1, '0);
    chk("ovf_clr", 32'(overflow), 32'(0));

    // Underflow and push+pop on empty.
    step(0, 0, 1, 0, '0);
    step(0, 1, 0, 0, '0);
    chk("unf_set", 32'(underflow), 32'(1));
    step(1, 1, 0, 0, 16'h00AA);
    chk("pp_empty_count", 32'(count), 32'(1));
    chk("pp_empty_top", 32'(top_out), 32'h00AA);
    chk("pp_empty_unf", 32'(underflow), 32'(1));
    step(0, 0, 0, 1, '0);

    // Replace top, then replace while full.
    step(0, 0, 1, 0, '0);
    step(1, 0, 0, 0, 16'h0005);
    step(1, 0, 0, 0, 16'h0007);
    step(1, 1, 0, 0, 16'h0009);
    chk("rep_pop_data", 32'(pop_data), 32'h0007);
    chk("rep_top", 32'(top_out), 32'h0009);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, DW'(16'h0100 + i));
    step(1, 1, 0, 0, 16'h0ABC);
    chk("rep_full_ovf", 32'(overflow), 32'(0));
    chk("rep_full_pop", 32'(pop_data), 32'h0102);

    // Asynchronous reset between edges.
    step(0, 0, 1, 0, '0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, DW'(16'h4000 + i));
    step(0, 1, 0, 0, '0);
    #1 reset = 1'b0;
    model_reset();
    #1 check_reset_state("async");
    @(posedge clk);
    #1 reset = 1'b1;
    step(0, 1, 0, 0, '0);
    chk("post_rst_unf", 32'(underflow), 32'(1));
    step(0, 0, 0, 1, '0);

    // Clear with push asserted.
    step(1, 0, 0, 0, 16'h7777);
    step(1, 0, 1, 0, 16'h8888);
    chk("clr_push_count", 32'(count), 32'(0));
    chk("clr_push_ovf", 32'(overflow), 32'(0));

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      op = $urandom_range(0, 99);
      step(op < 40 || (op >= 65 && op < 85), op >= 40 && op < 85, op >= 97,
           $urandom_range(0, 19) == 0, DW'($urandom));
    end
    step(0, 0, 0, 0, '0);
    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
